// File: rtl/wallace_pkg.sv
// Shared helpers for the pipelined Wallace multiplier: partial-product count,
// CSA tree depth, and the fixed pipeline latency.
package wallace_pkg;

    localparam int LAT = 3;

    // Radix-4 digits: two multiplier bits per partial product.
    function automatic int npp(input int nbits);
        return nbits / 2;
    endfunction

    // Rows left after 'lvl' levels of 3:2 compression starting from n rows.
    function automatic int rows_after(input int n, input int lvl);
        int r;
        r = n;
        for (int i = 0; i < lvl; i++) begin
            r = 2 * (r / 3) + (r % 3);
        end
        return r;
    endfunction

    // Number of 3:2 levels needed to bring n rows down to two.
    function automatic int csa_levels(input int n);
        int r;
        int l;
        r = n;
        l = 0;
        while (r > 2) begin
            r = 2 * (r / 3) + (r % 3);
            l++;
        end
        return l;
    endfunction

endpackage

// File: rtl/wallace_mult_pipe_csa_row.sv
// One row of 3:2 carry-save compression built from single-bit full adders.
// carry_o is returned unshifted; the caller aligns it one place up.
module full_adder_1bit (
    input  logic x_i,
    input  logic y_i,
    input  logic z_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = x_i ^ y_i ^ z_i;
    assign c_o = (x_i & y_i) | (x_i & z_i) | (y_i & z_i);
endmodule

module csa_row #(
    parameter int W = 8
) (
    input  logic [W-1:0] x_i,
    input  logic [W-1:0] y_i,
    input  logic [W-1:0] z_i,
    output logic [W-1:0] sum_o,
    output logic [W-1:0] carry_o
);
    for (genvar i = 0; i < W; i++) begin : g_fa
        full_adder_1bit u_fa (
            .x_i (x_i[i]),
            .y_i (y_i[i]),
            .z_i (z_i[i]),
            .s_o (sum_o[i]),
            .c_o (carry_o[i])
        );
    end
endmodule

// File: rtl/wallace_mult_pipe.sv
// Three-stage pipelined unsigned multiplier: radix-4 partial products (S1),
// generate-built Wallace CSA tree (S2), final carry-propagate add (S3).
// A single global stall freezes every stage while the output is blocked.
// Optional macro WALLACE_MAC_EN adds acc_clr and a running accumulator in S3.
module wallace_mult_pipe
    import wallace_pkg::*;
#(
    parameter int MBITS = 12,
    parameter int NBITS = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [MBITS-1:0]       a,
    input  logic [NBITS-1:0]       b,
`ifdef WALLACE_MAC_EN
    input  logic                   acc_clr,
`endif
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [MBITS+NBITS-1:0] result
);
    localparam int PW     = MBITS + NBITS;
    localparam int NPP    = npp(NBITS);
    localparam int LEVELS = csa_levels(NPP);

    if ((NBITS % 2) != 0 || NBITS < 4) begin : g_bad_nbits
        $error("wallace_mult_pipe: NBITS must be even and >= 4");
    end
    if (MBITS < 2) begin : g_bad_mbits
        $error("wallace_mult_pipe: MBITS must be >= 2");
    end

    // Handshake: a beat moves on a cycle with valid & ready. The whole pipe
    // stalls only when S3 holds a result the consumer is not taking.
    logic stall;
    assign stall     = out_valid & ~out_ready;
    assign in_ready  = ~stall;

    logic          s1_v_q, s2_v_q, s3_v_q;
    logic [PW-1:0] rows_d [NPP];
    logic [PW-1:0] rows_q [NPP];
    logic [PW-1:0] sum_q, carry_q;
    logic [PW-1:0] result_d, result_q;
    logic [PW-1:0] prod;

    // ---------------- S1: radix-4 partial products ----------------
    logic [MBITS+1:0] a3;
    assign a3 = {2'b00, a} + {1'b0, a, 1'b0};

    for (genvar k = 0; k < NPP; k++) begin : g_pp
        logic [1:0]       dig;
        logic [MBITS+1:0] pp;
        assign dig = b[2*k+1:2*k];
        // Select a*digit from the precomputed multiples.
        always_comb begin
            case (dig)
                2'd0:    pp = '0;
                2'd1:    pp = {2'b00, a};
                2'd2:    pp = {1'b0, a, 1'b0};
                default: pp = a3;
            endcase
        end
        assign rows_d[k] = PW'(pp) << (2 * k);
    end

`ifdef WALLACE_MAC_EN
    logic s1_clr_q, s2_clr_q;
    logic in_clr;
    assign in_clr = acc_clr;
`else
    logic in_clr;
    assign in_clr = 1'b1;
`endif

    // S1 register: stage valid plus the aligned partial-product rows.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v_q <= 1'b0;
            rows_q <= '{default: '0};
        end else if (!stall) begin
            s1_v_q <= in_valid;
            if (in_valid) rows_q <= rows_d;
        end
    end

    // ---------------- S2: Wallace CSA tree ----------------
    logic [PW-1:0] lvl [LEVELS+1][NPP];

    for (genvar k = 0; k < NPP; k++) begin : g_l0
        assign lvl[0][k] = rows_q[k];
    end

    for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
        localparam int CNT = rows_after(NPP, l);
        localparam int NG  = CNT / 3;
        localparam int NXT = rows_after(NPP, l + 1);
        for (genvar g = 0; g < NG; g++) begin : g_csa
            logic [PW-1:0] s, c;
            csa_row #(.W(PW)) u_row (
                .x_i     (lvl[l][3*g]),
                .y_i     (lvl[l][3*g+1]),
                .z_i     (lvl[l][3*g+2]),
                .sum_o   (s),
                .carry_o (c)
            );
            assign lvl[l+1][2*g]   = s;
            // Carry weight is one bit higher; the bit shifted past PW-1 is
            // dropped because the product always fits in PW bits.
            assign lvl[l+1][2*g+1] = c << 1;
        end
        for (genvar r = 0; r < CNT - 3 * NG; r++) begin : g_pass
            assign lvl[l+1][2*NG+r] = lvl[l][3*NG+r];
        end
        for (genvar u = NXT; u < NPP; u++) begin : g_zero
            assign lvl[l+1][u] = '0;
        end
    end

    // S2 register: the reduced sum/carry pair.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_v_q  <= 1'b0;
            sum_q   <= '0;
            carry_q <= '0;
        end else if (!stall) begin
            s2_v_q <= s1_v_q;
            if (s1_v_q) begin
                sum_q   <= lvl[LEVELS][0];
                carry_q <= lvl[LEVELS][1];
            end
        end
    end

    // ---------------- S3: final add (and optional accumulate) ----------------
    assign prod = sum_q + carry_q;

`ifdef WALLACE_MAC_EN
    logic [PW-1:0] acc_q;
    logic [PW-1:0] acc_base;
    // If S3 is occupied its beat is leaving this cycle, so it is the newest
    // departed result; otherwise the last departed result is in acc_q.
    assign acc_base = s3_v_q ? result_q : acc_q;
    assign result_d = s2_clr_q ? prod : acc_base + prod;

    // acc_clr travels with its beat through S1 and S2.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_clr_q <= 1'b0;
            s2_clr_q <= 1'b0;
        end else if (!stall) begin
            if (in_valid) s1_clr_q <= in_clr;
            if (s1_v_q)   s2_clr_q <= s1_clr_q;
        end
    end

    // Accumulator captures each result as it leaves S3.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else if (s3_v_q && out_ready) begin
            acc_q <= result_q;
        end
    end
`else
    logic unused_clr;
    assign unused_clr = in_clr;
    assign result_d   = prod;
`endif

    // S3 register: product (or accumulated sum) presented to the consumer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s3_v_q   <= 1'b0;
            result_q <= '0;
        end else if (!stall) begin
            s3_v_q <= s2_v_q;
            if (s2_v_q) result_q <= result_d;
        end
    end

    assign out_valid = s3_v_q;
    assign result    = result_q;

endmodule

// File: doc/wallace_mult_pipe.md
Name: wallace_mult_pipe

Overview:
- Parametrised, pipelined unsigned multiplier: result = a × b.
- Radix-4 partial-product generation feeds a generate-built 3:2 carry-save (Wallace) reduction, then a registered final carry-propagate add.
- Successor to the hand-coded 4-partial-product 12x8 tree: any even NBITS, 3-stage pipeline, valid/ready handshake.
- Sits between operand sources and the mults_check result comparators.

Parameters:
MBITS, 12, width of operand a (>=2)
NBITS, 8, width of operand b; must be even and >=4; NPP = NBITS/2 partial products
PW, MBITS+NBITS, product width (localparam, not overridable)

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
in_valid  input  1  operand beat valid
in_ready  output  1  block accepts beat this cycle
a  input  MBITS  multiplicand
b  input  NBITS  multiplier
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
result  output  PW  product

Behaviour:
- Reset:
  - rst=1 clears all stage valid flags and data registers.
  - out_valid=0, result=0. in_ready=1 once rst deasserts.
  - rst mid-operation discards all in-flight beats; no partial result is emitted.
- Stage S1 (register):
  - Digits d_k = b[2k+1:2k], k=0..NPP-1.
  - pp_k = a×d_k, width MBITS+2; 3a is precomputed as a + (a<<1).
  - pp_k is placed at bit offset 2k.
- Stage S2 (register): combinational 3:2 CSA levels reduce NPP aligned rows to a sum/carry pair, each PW bits. Carries are shifted left 1; bits above PW-1 are dropped.
- Stage S3 (register): result = sum + carry, modulo 2^PW. The true product always fits in PW bits.
- Latency: exactly 3 clk from an accepted beat (in_valid & in_ready) to out_valid for that beat when no stall occurs.
- Throughput: 1 beat/cycle.
- Handshake:
  - Global stall: stall = out_valid & ~out_ready; in_ready = ~stall.
  - During a stall every stage register holds; result and out_valid stay stable.
  - Bubbles (in_valid=0) propagate as invalid stages. Bubbles are not collapsed during a stall.
  - Beats leave strictly in acceptance order; no drop, no duplication.
- Simultaneous events:
  - out_ready rising in the same cycle as in_valid: the beat is accepted and S3 advances.
  - in_valid while in_ready=0: the beat is ignored. The source must hold it (AXI-style).
- Parameter check: an elaboration-time error fires if NBITS is odd or <4.

Optional Feature:
- Macro WALLACE_MAC_EN.
- Defined:
  - Adds input port acc_clr (1 bit), sampled with each accepted beat and carried down the pipeline.
  - Adds a PW-bit accumulator in S3.
  - For a beat with acc_clr=1: result = product.
  - Otherwise: result = previous result + product, modulo 2^PW (wraps silently).
  - The accumulator updates only when a beat leaves S3. It is cleared by rst.
- Undefined: no acc_clr port; result = product only.

Decomposition:
- Package wallace_pkg holds:
  - function npp(NBITS)
  - function csa_levels(n): number of 3:2 levels to reduce n rows to 2
  - localparam LAT=3
- Sub-module csa_row (parameter W): a W-bit row of full_adder_1bit cells producing sum[W-1:0] and carry[W-1:0]. Instantiated per level by a generate loop.
- The final adder is inline in S3.

Test Plan:
- Reset mid-stream: assert rst with 3 beats in flight -> out_valid=0 and result=0 immediately (async); no stale beat appears after release.
- Corners, MBITS=12, NBITS=8, out_ready=1:
  - a=4095, b=255 -> result=1044225, exactly 3 cycles after acceptance.
  - a=0, b=255 -> 0.
  - a=1, b=1 -> 1.
- Streaming: 200 random back-to-back beats, out_ready=1 -> one result per cycle, in order, each equal to the reference model.
- Backpressure:
  - out_ready=0 for 5 cycles with the pipe full -> in_ready=0 and result held constant.
  - On release, results resume in order with no loss.
  - Also run random out_ready toggling at 50%.
- Parameter sweep: MBITS=16/NBITS=16 and MBITS=4/NBITS=4, exhaustive for 4x4 -> all 256 products correct.
- WALLACE_MAC_EN, MBITS=12, NBITS=8:
  - (3,5,acc_clr=1) then (7,11,0) -> results 15, then 92.
  - Repeated 4095×255 with acc_clr=0 -> wraps modulo 2^20.
